// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//
// Iterative multiply/divide unit with architectural HI/LO registers for the
// multi-cycle MIPS datapath. One bit of the result is produced per clock:
// shift-add for MULT/MULTU, restoring division for DIV/DIVU. Signed
// operations work on magnitudes and fix the signs up in the final cycle.
//
// Ports:
//   clk    - system clock, all state changes on the rising edge
//   rst    - synchronous active-high reset
//   start  - begin a new operation (only looked at while idle)
//   op     - 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a      - rs operand: multiplicand / dividend
//   b      - rt operand: multiplier / divisor
//   hi_we  - MTHI write enable (ignored while busy)
//   lo_we  - MTLO write enable (ignored while busy)
//   wdata  - MTHI/MTLO write data
//   busy   - operation in progress (33 cycles per operation)
//   done   - one-cycle pulse when HI/LO receive a new result
//   hi     - HI register: product high word / remainder
//   lo     - LO register: product low word / quotient
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    state_t             state_reg, state_next;
    logic [5:0]         counter_reg;
    logic               is_div_reg;
    logic               sign_a_reg;
    logic               sign_b_reg;
    logic               div_zero_reg;
    logic [WIDTH-1:0]   a_raw_reg;
    // Multiplicand for multiply, divisor for divide (both as magnitudes).
    logic [WIDTH-1:0]   operand_reg;
    // Multiply: {partial product high, remaining multiplier bits}.
    // Divide: low half holds dividend bits shifting out / quotient shifting in.
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH:0]     rem_reg, rem_next;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               done_reg;

    // Magnitudes of the incoming operands; signed ops only.
    logic               op_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign op_signed = op[0];
    assign a_neg     = op_signed & a[WIDTH-1];
    assign b_neg     = op_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? (~a + 1'b1) : a;
    assign b_mag     = b_neg ? (~b + 1'b1) : b;

    // ---------------------------------------------------------------------
    // FSM next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (counter_reg == LAST_ITER) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // One iteration of the shift-add multiply or restoring divide
    // ---------------------------------------------------------------------
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] rem_diff;

    always_comb begin
        mul_sum   = '0;
        rem_shift = '0;
        rem_diff  = '0;
        acc_next  = acc_reg;
        rem_next  = rem_reg;
        if (is_div_reg) begin
            // Bring down the next dividend bit and trial-subtract the divisor.
            rem_shift = {rem_reg[WIDTH-1:0], acc_reg[WIDTH-1]};
            rem_diff  = rem_shift - {1'b0, operand_reg};
            if (!rem_diff[WIDTH]) begin
                rem_next = rem_diff;
                acc_next = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-2:0], 1'b1};
            end else begin
                rem_next = rem_shift;
                acc_next = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Add the multiplicand into the high half when the current
            // multiplier bit is set, then shift the whole thing right with
            // the carry entering at the top.
            mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                     + (acc_reg[0] ? {1'b0, operand_reg} : '0);
            acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
        end
    end

    // ---------------------------------------------------------------------
    // Sign correction of the final result
    // ---------------------------------------------------------------------
    logic               neg_result;
    logic [2*WIDTH-1:0] product_fixed;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    assign neg_result    = sign_a_reg ^ sign_b_reg;
    assign product_fixed = neg_result ? (~acc_reg + 1'b1) : acc_reg;
    assign quot_fixed    = neg_result ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];
    assign rem_fixed     = sign_a_reg ? (~rem_reg[WIDTH-1:0] + 1'b1) : rem_reg[WIDTH-1:0];

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            counter_reg  <= '0;
            is_div_reg   <= 1'b0;
            sign_a_reg   <= 1'b0;
            sign_b_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
            a_raw_reg    <= '0;
            operand_reg  <= '0;
            acc_reg      <= '0;
            rem_reg      <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // MTHI/MTLO land here; a simultaneous start simply
                    // overwrites them when its result is written.
                    if (hi_we) hi_reg <= wdata;
                    if (lo_we) lo_reg <= wdata;
                    if (start) begin
                        is_div_reg   <= op[1];
                        sign_a_reg   <= a_neg;
                        sign_b_reg   <= b_neg;
                        div_zero_reg <= op[1] && (b == '0);
                        a_raw_reg    <= a;
                        counter_reg  <= '0;
                        rem_reg      <= '0;
                        if (op[1]) begin
                            operand_reg <= b_mag;
                            acc_reg     <= {{WIDTH{1'b0}}, a_mag};
                        end else begin
                            operand_reg <= a_mag;
                            acc_reg     <= {{WIDTH{1'b0}}, b_mag};
                        end
                    end
                end
                CALC: begin
                    counter_reg <= counter_reg + 6'd1;
                    acc_reg     <= acc_next;
                    rem_reg     <= rem_next;
                end
                FINISH: begin
                    done_reg <= 1'b1;
                    if (!is_div_reg) begin
                        hi_reg <= product_fixed[2*WIDTH-1:WIDTH];
                        lo_reg <= product_fixed[WIDTH-1:0];
                    end else if (div_zero_reg) begin
                        // Divide by zero bypasses sign correction entirely.
                        hi_reg <= a_raw_reg;
                        lo_reg <= '1;
                    end else begin
                        hi_reg <= rem_fixed;
                        lo_reg <= quot_fixed;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//
// Directed-vector bench for mul_div_unit. A table of operations with
// hand-computed HI/LO results is issued back to back (each new start in the
// previous done cycle), followed by hand-written sequences for ignored
// starts, dropped MTLO, MTHI, and reset in mid-operation.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    int n_cmp;
    int n_err;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issue one operation starting at a negedge. Returns at the negedge of the
    // done cycle so the caller may issue the next start right away.
    // If poke is set, at busy cycle 5 a second start with other operands and
    // an MTLO write are presented; both must be ignored.
    task automatic run_op(input string name, input logic [1:0] f_op,
                          input logic [31:0] f_a, input logic [31:0] f_b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit poke);
        int          cycles;
        bit          stable;
        bit          early_done;
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        start = 1'b1;
        op    = f_op;
        a     = f_a;
        b     = f_b;
        @(negedge clk);
        start      = 1'b0;
        prev_hi    = hi;
        prev_lo    = lo;
        stable     = 1'b1;
        early_done = 1'b0;
        cycles     = 0;
        while (busy && cycles < 100) begin
            cycles++;
            if (done) early_done = 1'b1;
            if (hi !== prev_hi || lo !== prev_lo) stable = 1'b0;
            if (poke && cycles == 5) begin
                start = 1'b1;
                op    = OP_MULTU;
                a     = 32'd100;
                b     = 32'd200;
                lo_we = 1'b1;
                wdata = 32'h0000_0001;
            end else begin
                start = 1'b0;
                lo_we = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        lo_we = 1'b0;
        $display("%s: op=%0d a=0x%08h b=0x%08h busy_cycles=%0d hi=0x%08h lo=0x%08h done=%0b",
                 name, f_op, f_a, f_b, cycles, hi, lo, done);
        check({name, " busy_cycles"}, 32'(cycles), 32'd33);
        check({name, " done"}, {31'd0, done}, 32'd1);
        check({name, " no_early_done"}, {31'd0, early_done}, 32'd0);
        check({name, " hilo_stable"}, {31'd0, stable}, 32'd1);
        check({name, " hi"}, hi, exp_hi);
        check({name, " lo"}, lo, exp_lo);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;

        vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
        vecs[3] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{OP_DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
        vecs[6] = '{OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8] = '{OP_DIV,   32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        $display("reset: busy=%0b done=%0b hi=0x%08h lo=0x%08h", busy, done, hi, lo);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);

        // Table: every operation starts in the done cycle of the previous one.
        for (int i = 0; i < NVEC; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, 1'b0);
        end
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);

        // MTHI in idle.
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        hi_we = 1'b0;
        $display("mthi: hi=0x%08h", hi);
        check("mthi hi", hi, 32'hDEAD_BEEF);

        // MULTU 5*6 with an ignored start and a dropped MTLO in flight.
        run_op("ignore_start", OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b1);
        @(negedge clk);

        // Reset in mid-operation aborts it.
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("mid_reset: busy=%0b done=%0b hi=0x%08h lo=0x%08h", busy, done, hi, lo);
        check("mid_reset busy", {31'd0, busy}, 32'd0);
        check("mid_reset done", {31'd0, done}, 32'd0);
        check("mid_reset hi", hi, 32'd0);
        check("mid_reset lo", lo, 32'd0);
        repeat (40) @(negedge clk);
        check("after_reset idle hi", hi, 32'd0);
        check("after_reset idle lo", lo, 32'd0);

        // Fresh operation after reset.
        run_op("post_reset", OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative 32-bit multiply/divide unit for the multi-cycle MIPS datapath. It sits directly downstream of Register_File.
- Operands come from the RD1/RD2 register-file read ports; results go to architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU in a fixed number of cycles under a start/busy/done handshake.
- Supports MTHI/MTLO writes. HI/LO are read combinationally by the datapath for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is verified.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when busy=0.
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  input  WIDTH  operand rs (RD1); dividend or multiplicand.
- b  input  WIDTH  operand rt (RD2); divisor or multiplier.
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO hold a new result.
- hi  output  WIDTH  HI register (product high word / remainder).
- lo  output  WIDTH  LO register (product low word / quotient).

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset overrides every other input.
- Reset mid-operation aborts the operation; no partial result reaches hi/lo.
- FSM states: IDLE -> CALC -> FINISH -> IDLE.
- IDLE:
  - start=1 at edge E0: latch op, latch sign flags of a and b, and latch |a| and |b|. Absolute values apply to signed ops only; unsigned ops latch raw values. Clear the 6-bit counter and go to CALC. busy=1 from E0.
- CALC: one iteration per edge for 32 edges (E1..E32), then go to FINISH.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring division with a 33-bit partial remainder.
- FINISH: at edge E33:
  - Apply sign correction. Product is negated if sign_a^sign_b. Quotient is negated if sign_a^sign_b. Remainder takes the sign of the dividend (sign_a).
  - Write hi/lo, set done=1, set busy=0, return to IDLE.
- Latency: busy is high for exactly 33 cycles. done is high for the single cycle after E33. A new start is accepted in that same cycle.
- Result mapping:
  - Multiply: hi=product[63:32], lo=product[31:0].
  - Divide: lo=quotient, hi=remainder.
- Divide by zero (b=0, DIV or DIVU): normal latency, lo=32'hFFFFFFFF, hi=a (original, unsigned-reinterpreted value).
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. Wraps, no trap.
- start while busy=1: ignored; no queuing; the in-flight operation is unaffected.
- hi_we/lo_we:
  - Honoured only when busy=0; take effect at that edge. Writes while busy=1 are dropped.
  - hi_we, lo_we and start together in IDLE: the writes take effect at E0 and are overwritten at E33.
- hi/lo outputs are stable throughout CALC. They hold their previous values until E33.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 busy cycles: done pulse, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIVU a=7, b=2 issued in the done cycle -> lo=3, hi=1, 33 cycles later.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, done at normal latency.
- Start MULTU 5*6:
  - Pulse start again at cycle 5 with different operands: ignored; result is hi=0, lo=30.
  - Restart, then assert rst at cycle 10: next cycle busy=0, done=0, hi=lo=0.
  - Fresh start after reset completes correctly.
- MTHI wdata=0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle. MTLO wdata=0x1 while busy -> dropped; lo equals the computed result at done.
